// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit per frame).
package uart_pkg;

  localparam int DATA_W = 8;

`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_t;
`else
  localparam int PARITY_BITS = 0;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_STOP   = 3'd5
  } state_t;
`endif

  // start bit + data bits + one stop bit
  localparam int FRAME_TICKS_BASE = 1 + DATA_W + 1;

  // Bit periods per frame for a given stop-bit count.
  function automatic int frame_ticks(input int stop_bits);
    return FRAME_TICKS_BASE + PARITY_BITS + stop_bits - 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin requester selection: search starts one above last_grant and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic            hi_found;
  logic            lo_found;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;

  // Lowest requester above last_grant, and lowest requester overall for the wrap case.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (i > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
  end

  // Prefer the above-last_grant winner; fall back to the wrapped one.
  always_comb begin
    grant_idx = hi_found ? hi_idx : lo_idx;
    grant     = '0;
    if (hi_found || lo_found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Multi-requester UART transmitter; bit timing comes only from tx_clk_en.
// Optional feature macro: UART_TX_PARITY_EN (even-parity bit between data and stop).
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | line high, arbitrating; byte accepted on transfer
// ST_WAIT   | byte latched, waiting for the tick that starts the start bit
// ST_START  | start bit (tx=0) on the line
// ST_DATA   | data bit bit_cnt on the line, LSB first
// ST_PARITY | even-parity bit on the line (parity build only)
// ST_STOP   | stop bit(s) on the line; bit_cnt counts stop periods
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int STOP_BITS = 1,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_clk_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      tx
);

  state_t              state_q, state_d;
  logic                tx_q, tx_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [2:0]          bit_cnt_nxt;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]     arb_idx;
  logic [DATA_W-1:0]   sel_byte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  assign bit_cnt_nxt = bit_cnt_q + 3'd1;

  // Byte of the currently selected requester.
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_byte = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Next-state and handshake logic; everything past IDLE moves only on a tick.
  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    case (state_q)
      ST_IDLE: begin
        if (rst) req_ready = arb_grant & req_valid;
        if (|req_ready) begin
          data_d       = sel_byte;
          grant_id_d   = arb_idx;
          last_grant_d = arb_idx;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_clk_en) begin
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tx_clk_en) begin
          tx_d      = data_q[0];
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_clk_en) begin
          if (bit_cnt_q != 3'd7) begin
            tx_d      = data_q[bit_cnt_nxt];
            bit_cnt_d = bit_cnt_nxt;
          end else begin
            bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            tx_d      = ^data_q;
            state_d   = ST_PARITY;
`else
            tx_d      = 1'b1;
            state_d   = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tx_clk_en) begin
          tx_d      = 1'b1;
          bit_cnt_d = 3'd0;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tx_clk_en) begin
          if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
            bit_cnt_d = 3'd0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_nxt;
          end
        end
      end
      default: begin
        tx_d      = 1'b1;
        bit_cnt_d = 3'd0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any frame and gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      tx_q         <= 1'b1;
      bit_cnt_q    <= 3'd0;
      data_q       <= '0;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign tx       = tx_q;
  assign grant_id = grant_id_q;

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the transmitter (1..8).
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tx_clk_en  input  1  one-cycle baud tick from the baud rate generator.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester byte-pending flag.
REQ-007 SHALL have port req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot acceptance strobe.
REQ-009 SHALL have port grant_id  output  $clog2(NUM_REQ) (min 1)  index of requester owning the current frame.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port tx  output  1  serial line, registered, idle high.

Function
REQ-012 SHALL implement states IDLE, WAIT, START, DATA, PARITY (PARITY_EN only), STOP.
REQ-013 In IDLE with any req_valid set, SHALL select one requester round-robin, starting the search at last_grant+1 and wrapping at NUM_REQ-1.
REQ-014 req_ready[i] SHALL be combinational: high only in IDLE, only for the selected i, only while req_valid[i] is high.
REQ-015 Transfer occurs on a cycle with req_valid[i] & req_ready[i]; SHALL latch the byte, set grant_id=i, update last_grant=i, and go to WAIT.
REQ-016 last_grant SHALL change only on a transfer; a requester dropping req_valid before transfer SHALL NOT lock arbitration.
REQ-017 tx and state SHALL advance only on cycles with tx_clk_en=1 in WAIT..STOP; tx_clk_en in IDLE SHALL be ignored.
REQ-018 WAIT, on tick: tx<=0, go to START.
REQ-019 START, on tick: tx<=data[0], bit_cnt<=0, go to DATA.
REQ-020 DATA, on tick: if bit_cnt<7, tx<=data[bit_cnt+1] and increment; if bit_cnt==7, go to PARITY (tx<=parity) or STOP (tx<=1).
REQ-021 STOP SHALL hold tx=1 for STOP_BITS ticks, then go to IDLE.
REQ-022 Each bit SHALL last exactly one tick period; frame length SHALL be 10 ticks with 1 stop bit, +1 with PARITY_EN, +1 with STOP_BITS=2, LSB first.
REQ-023 SHALL be able to accept the next byte in the first IDLE cycle after STOP, with no extra idle ticks.

Reset
REQ-024 On a clk edge with rst=0, SHALL set tx=1, state=IDLE, busy=0, bit_cnt=0, grant_id=0, and last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-025 While rst=0, req_ready SHALL be all-zero.
REQ-026 Reset mid-frame SHALL abort the frame, drive tx=1 after the next edge, and discard the byte without a retry.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, SHALL insert one even-parity bit (XOR of the 8 data bits) between DATA and STOP.
REQ-028 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP.

Structure
REQ-029 Package uart_pkg SHALL hold the state enumeration, the DATA_W=8 constant and the frame-length constants.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant, index).
REQ-031 The scheduler SHALL contain no baud counter; timing SHALL come solely from tx_clk_en.

Verification
REQ-032 Single requester: after reset, req_valid=4'b0001, byte 8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 on consecutive ticks; req_ready[0] pulses one cycle.
REQ-033 Contention: req_valid=4'b1111 held, bytes 8'h10/8'h20/8'h30/8'h40 -> frames sent in order 0,1,2,3, then 0 again; grant_id matches each frame.
REQ-034 Fairness: req_valid=4'b0101 continuous -> frames alternate 0,2,0,2; requesters 1 and 3 never get req_ready.
REQ-035 Withdrawn request: req_valid[1] high for 3 cycles while busy, then low -> no frame for requester 1; last_grant unchanged.
REQ-036 Reset mid-frame: assert rst=0 during bit 4 of 8'hFF -> tx=1 after the next edge, busy=0; the next request starts from requester 0.
REQ-037 With UART_TX_PARITY_EN defined, send 8'h07 -> 11-tick frame with parity bit 1; 8'h03 -> parity bit 0.
